// File: rtl/i2c_primary.sv
// i2c_primary: I2C controller issuing one fixed-format transaction per request:
// START, {addr,rnw} + ack, HI byte + ack, LO byte + ack, STOP.
// Each bit slot is four quarters of QDIV clk cycles; SCL is low in Q0/Q1 and
// high in Q2/Q3. SDA only moves on entry to Q0, apart from the START and STOP
// quarters. SDA_IN is sampled on the edge that enters Q3.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start_stb         one-cycle request, taken only while idle
//   rnw, i2c_addr,    request fields, captured on accept
//   wr_data
//   sda_in            SDA level returned by the secondary
//   scl, sda_out,     bus clock and SDA drive (sda_out is 1 while released)
//   sda_oe
//   rd_data           read result, loaded only when a read completes cleanly
//   busy, done, nack  status: in progress, end pulse, sticky ack failure
//
// state     | meaning
// IDLE      | bus idle, waiting for start_stb
// START     | SDA falls while SCL is high
// ADDR      | 8 slots: {addr,rnw}, MSB first
// ACK_A     | SDA released, secondary acks the address
// WR_BYTE   | 8 slots: HI then LO write byte, MSB first
// ACK_W     | SDA released, secondary acks the write byte
// RD_BYTE   | 8 slots: SDA released, shift in HI then LO
// ACK_R     | primary acks HI, nacks LO
// STOP      | SDA rises while SCL is high
module i2c_primary #(
  parameter int unsigned QDIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stb,
  input  logic        rnw,
  input  logic [6:0]  i2c_addr,
  input  logic [15:0] wr_data,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_out,
  output logic        sda_oe,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_WR_BYTE, S_ACK_W, S_RD_BYTE, S_ACK_R, S_STOP
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(QDIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic        lo_q, lo_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        smp_q, smp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        q_end, smp_edge, slot_end;
  logic [7:0]  addr_byte;

  assign addr_byte = {addr_q, rnw_q};
  assign q_end     = (div_q == 8'd0);
  assign smp_edge  = q_end && (qtr_q == 2'd2);
  assign slot_end  = q_end && (qtr_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= DIV_LOAD;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      lo_q      <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 16'd0;
      shadow_q  <= 16'd0;
      rd_data_q <= 16'd0;
      smp_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      lo_q      <= lo_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      smp_q     <= smp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    lo_d      = lo_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rd_data_d = rd_data_q;
    smp_d     = smp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    if (state_q == S_IDLE) begin
      // Hold the quarter timer preloaded so START Q0 lasts a full QDIV.
      div_d = DIV_LOAD;
      qtr_d = 2'd0;
      if (start_stb) begin
        rnw_d   = rnw;
        addr_d  = i2c_addr;
        wdata_d = wr_data;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = S_START;
      end
    end else begin
      div_d = q_end ? DIV_LOAD : div_q - 8'd1;
      if (q_end) qtr_d = qtr_q + 2'd1;
      if (smp_edge) begin
        smp_d = sda_in;
        if (state_q == S_RD_BYTE) shadow_d = {shadow_q[14:0], sda_in};
      end
      if (slot_end) begin
        case (state_q)
          S_START: begin
            state_d = S_ADDR;
            bit_d   = 3'd7;
          end
          S_ADDR: begin
            if (bit_q == 3'd0) state_d = S_ACK_A;
            else               bit_d   = bit_q - 3'd1;
          end
          S_ACK_A: begin
            bit_d = 3'd7;
            lo_d  = 1'b0;
            if (smp_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              state_d = rnw_q ? S_RD_BYTE : S_WR_BYTE;
            end
          end
          S_WR_BYTE: begin
            if (bit_q == 3'd0) state_d = S_ACK_W;
            else               bit_d   = bit_q - 3'd1;
          end
          S_ACK_W: begin
            if (smp_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (lo_q) begin
              state_d = S_STOP;
            end else begin
              lo_d    = 1'b1;
              bit_d   = 3'd7;
              state_d = S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (bit_q == 3'd0) state_d = S_ACK_R;
            else               bit_d   = bit_q - 3'd1;
          end
          S_ACK_R: begin
            if (lo_q) begin
              state_d = S_STOP;
            end else begin
              lo_d    = 1'b1;
              bit_d   = 3'd7;
              state_d = S_RD_BYTE;
            end
          end
          S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rnw_q && !nack_q) rd_data_d = shadow_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    scl     = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b1;
    case (state_q)
      S_IDLE:  ;
      S_START: sda_out = ~qtr_q[1];
      S_ADDR: begin
        scl     = qtr_q[1];
        sda_out = addr_byte[bit_q];
      end
      S_ACK_A, S_ACK_W, S_RD_BYTE: begin
        scl    = qtr_q[1];
        sda_oe = 1'b0;
      end
      S_WR_BYTE: begin
        scl     = qtr_q[1];
        sda_out = wdata_q[{~lo_q, bit_q}];
      end
      S_ACK_R: begin
        // Ack the HI byte, nack the LO byte to end the read.
        scl     = qtr_q[1];
        sda_out = lo_q;
      end
      S_STOP: begin
        scl     = qtr_q[1];
        sda_out = (qtr_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_primary.sv
module tb_i2c_primary;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_stb, rnw, sel;
  logic [6:0]  i2c_addr;
  logic [15:0] wr_data;
  logic        sda_in = 1'b1;
  logic        stb1, stb3;

  logic        scl1, sdo1, soe1, busy1, done1, nack1;
  logic        scl3, sdo3, soe3, busy3, done3, nack3;
  logic [15:0] rd1, rd3;

  logic        scl, sda_out, sda_oe, busy, done, nack;
  logic [15:0] rd_data;

  assign stb1 = start_stb & ~sel;
  assign stb3 = start_stb & sel;

  i2c_primary #(.QDIV(1)) dut1 (
    .clk(clk), .reset(reset), .start_stb(stb1), .rnw(rnw), .i2c_addr(i2c_addr),
    .wr_data(wr_data), .sda_in(sda_in), .scl(scl1), .sda_out(sdo1), .sda_oe(soe1),
    .rd_data(rd1), .busy(busy1), .done(done1), .nack(nack1)
  );

  i2c_primary #(.QDIV(3)) dut3 (
    .clk(clk), .reset(reset), .start_stb(stb3), .rnw(rnw), .i2c_addr(i2c_addr),
    .wr_data(wr_data), .sda_in(sda_in), .scl(scl3), .sda_out(sdo3), .sda_oe(soe3),
    .rd_data(rd3), .busy(busy3), .done(done3), .nack(nack3)
  );

  assign scl     = sel ? scl3  : scl1;
  assign sda_out = sel ? sdo3  : sdo1;
  assign sda_oe  = sel ? soe3  : soe1;
  assign busy    = sel ? busy3 : busy1;
  assign done    = sel ? done3 : done1;
  assign nack    = sel ? nack3 : nack1;
  assign rd_data = sel ? rd3   : rd1;

  typedef struct {
    logic        rnw;
    logic        nack;
    logic [15:0] rd;
    logic [15:0] rd_prev;
    int          cycles;
    int          slots;
    logic [7:0]  addr_byte;
    logic [15:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Secondary model and bus observer: counts SCL falls after START, drives
  // acks/read data on falls, records effective SDA on SCL rises.
  logic [15:0] m_rd = 16'h1234;
  logic        m_ack_addr = 1'b1;
  logic        m_ack_hi = 1'b1;
  logic        bits [0:31];
  int          fall_cnt = 0, rise_cnt = 0, run = 0;
  int          edge_viol = 0, scl_viol = 0, stop_fall = 99;
  logic        in_txn = 1'b0;
  logic        p_scl = 1'b1, p_sda = 1'b1;
  logic        ob_c, ob_s;

  function automatic logic model_drive(input int k);
    if (k == 9) return ~m_ack_addr;
    if (!m_ack_addr) return 1'b1;
    if (bits[8]) begin
      if (k >= 10 && k <= 17) return m_rd[25 - k];
      if (k >= 19 && k <= 26) return m_rd[26 - k];
      return 1'b1;
    end
    if (k == 18) return ~m_ack_hi;
    if (k == 27) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    ob_c = scl;
    ob_s = sda_out & sda_in;
    if (reset) begin
      in_txn   = 1'b0;
      fall_cnt = 0;
      rise_cnt = 0;
      run      = 0;
      sda_in   = 1'b1;
    end else begin
      if (ob_c != p_scl) begin
        if (in_txn) begin
          if (!ob_c && fall_cnt > 0 && run != (sel ? 6 : 2)) scl_viol++;
          if (ob_c && run != (sel ? 6 : 2)) scl_viol++;
        end
        run = 1;
      end else begin
        run++;
      end
      if (p_scl && ob_c && ob_s != p_sda) begin
        if (!ob_s && !in_txn) begin
          in_txn    = 1'b1;
          fall_cnt  = 0;
          rise_cnt  = 0;
          edge_viol = 0;
          scl_viol  = 0;
          stop_fall = 99;
        end else if (ob_s && in_txn) begin
          in_txn    = 1'b0;
          stop_fall = fall_cnt;
        end else if (in_txn) begin
          edge_viol++;
        end
      end
      if (in_txn && p_scl && !ob_c) begin
        fall_cnt++;
        sda_in = model_drive(fall_cnt);
      end
      if (in_txn && !p_scl && ob_c) begin
        rise_cnt++;
        if (rise_cnt < 32) bits[rise_cnt] = ob_s;
      end
    end
    p_scl = ob_c;
    p_sda = ob_s;
  end

  function automatic logic [7:0] get_byte(input int first);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = bits[first + i];
    return b;
  endfunction

  // Scoreboard monitor: pops one expectation per DONE pulse.
  int   busy_cnt = 0;
  logic rd_early = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy_cnt = 0;
      rd_early = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() > 0 && rd_data !== exp_q[0].rd_prev) rd_early = 1'b1;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cycles", busy_cnt, mon_e.cycles);
          chk("nack", 32'(nack), 32'(mon_e.nack));
          chk("rd_data", 32'(rd_data), 32'(mon_e.rd));
          chk("rd_stable", 32'(rd_early), 32'd0);
          chk("addr_byte", 32'(get_byte(1)), 32'(mon_e.addr_byte));
          chk("stop_slot", stop_fall, mon_e.slots - 1);
          chk("sda_edge", edge_viol, 0);
          chk("scl_width", scl_viol, 0);
          if (!mon_e.rnw && mon_e.slots >= 20)
            chk("hi_byte", 32'(get_byte(10)), 32'(mon_e.wdata[15:8]));
          if (!mon_e.rnw && mon_e.slots == 29)
            chk("lo_byte", 32'(get_byte(19)), 32'(mon_e.wdata[7:0]));
          if (mon_e.rnw && !mon_e.nack)
            chk("rd_ack_bits", {30'd0, bits[18], bits[27]}, 32'd1);
          busy_cnt = 0;
          rd_early = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic r, input logic [6:0] a, input logic [15:0] d,
                       input logic [7:0] ab, input logic n, input logic [15:0] rd_exp,
                       input logic [15:0] rd_prev, input int cyc, input int slots);
    exp_t e;
    e.rnw = r; e.nack = n; e.rd = rd_exp; e.rd_prev = rd_prev;
    e.cycles = cyc; e.slots = slots; e.addr_byte = ab; e.wdata = d;
    exp_q.push_back(e);
    rnw = r;
    i2c_addr = a;
    wr_data = d;
    start_stb = 1'b1;
    tick();
    start_stb = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start_stb = 1'b0; rnw = 1'b0; i2c_addr = 7'd0; wr_data = 16'd0; sel = 1'b0;
    repeat (3) tick();
    chk("reset_ctl", {26'd0, scl, sda_out, sda_oe, busy, done, nack}, 32'b111000);
    chk("reset_rd", 32'(rd_data), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Write 0x2A / 0xBEEF, then a read issued in the DONE cycle.
    issue(1'b0, 7'h2A, 16'hBEEF, 8'h54, 1'b0, 16'h0000, 16'h0000, 116, 29);
    wait_done(200);
    issue(1'b1, 7'h2A, 16'h0000, 8'h55, 1'b0, 16'h1234, 16'h0000, 116, 29);
    wait_done(200);
    tick();

    // Read to an absent secondary: address NACK, RD_DATA kept.
    m_ack_addr = 1'b0;
    issue(1'b1, 7'h2A, 16'h0000, 8'h55, 1'b1, 16'h1234, 16'h1234, 44, 11);
    wait_done(200);
    tick();
    m_ack_addr = 1'b1;

    // Write whose HI byte is nacked.
    m_ack_hi = 1'b0;
    issue(1'b0, 7'h10, 16'hFFFF, 8'h20, 1'b1, 16'h1234, 16'h1234, 80, 20);
    wait_done(200);
    tick();
    m_ack_hi = 1'b1;

    // Write with a conflicting request strobed while busy.
    issue(1'b0, 7'h51, 16'hA55A, 8'hA2, 1'b0, 16'h1234, 16'h1234, 116, 29);
    repeat (40) tick();
    rnw = 1'b1; i2c_addr = 7'h0F; wr_data = 16'h1234; start_stb = 1'b1;
    tick();
    start_stb = 1'b0;
    wait_done(200);
    tick();

    // Reset during the HI write byte.
    issue(1'b0, 7'h33, 16'h5555, 8'h66, 1'b0, 16'h1234, 16'h1234, 116, 29);
    n = 0;
    while (fall_cnt != 12 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_point", fall_cnt, 12);
    reset = 1'b1;
    tick();
    chk("abort_ctl", {26'd0, scl, sda_out, sda_oe, busy, done, nack}, 32'b111000);
    chk("abort_rd", 32'(rd_data), 32'd0);
    reset = 1'b0;
    exp_q.delete(0);
    repeat (3) tick();

    // Fresh write after the reset.
    issue(1'b0, 7'h7F, 16'h0001, 8'hFE, 1'b0, 16'h0000, 16'h0000, 116, 29);
    wait_done(200);
    repeat (2) tick();

    // QDIV=3 instance.
    sel = 1'b1;
    repeat (2) tick();
    issue(1'b0, 7'h2A, 16'hC3A5, 8'h54, 1'b0, 16'h0000, 16'h0000, 348, 29);
    wait_done(500);
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_primary.md
# i2c_primary

I2C primary (controller) that generates the bus traffic consumed by the team's I2C secondary. It produces SCL and SDA_OUT/SDA_OE, samples SDA_IN returned by the secondary, and runs one fixed-format transaction per request: START, 7-bit address + RNW, ACK, two data bytes (HI then LO) with per-byte acknowledge, STOP. It sits between the host-side register logic and the secondary, using the same wired-AND SDA convention (effective SDA = SDA_OUT & SDA_IN).

## Interface
- QDIV, 1, CLK cycles per SCL quarter-period; legal range 1..255.
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START_STB  in  1  one-cycle request; accepted only when BUSY=0.
- RNW  in  1  1 = read, 0 = write; captured on accept.
- I2C_ADDR  in  7  target secondary address; captured on accept.
- WR_DATA  in  16  write payload {HI,LO}; captured on accept.
- SDA_IN  in  1  SDA level returned by the secondary (1 = released).
- SCL  out  1  bus clock.
- SDA_OUT  out  1  SDA driven by primary; forced 1 whenever SDA_OE=0.
- SDA_OE  out  1  1 = primary owns SDA.
- RD_DATA  out  16  read result {HI,LO}; updated only at end of a successful read.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse at transaction end (success or NACK).
- NACK  out  1  sticky: a secondary ACK slot sampled 1; cleared on next accept.

## Operation
- Reset values: SCL=1, SDA_OUT=1, SDA_OE=1, RD_DATA=0, BUSY=0, DONE=0, NACK=0, state IDLE.
- Bit slot = 4 quarters (Q0..Q3), each QDIV cycles. SCL=0 in Q0,Q1; SCL=1 in Q2,Q3. SDA_OUT/SDA_OE change only on entry to Q0. SDA_IN sampled on the cycle entering Q3.
- States: IDLE, START, ADDR, ACK_A, WR_BYTE, ACK_W, RD_BYTE, ACK_R, STOP.
- IDLE: SCL=1, SDA_OUT=1, SDA_OE=1. START_STB=1 -> capture inputs, NACK<=0, BUSY<=1, go START.
- START (1 slot): SDA_OUT=1 in Q0,Q1, SDA_OUT=0 in Q2,Q3, SCL=1 throughout (falling SDA while SCL high).
- ADDR (8 slots): shift {I2C_ADDR,RNW} MSB first, SDA_OE=1.
- ACK_A (1 slot): SDA_OE=0, SDA_OUT=1. Sample 0 -> WR_BYTE (RNW=0) or RD_BYTE (RNW=1); sample 1 -> NACK<=1, STOP.
- WR_BYTE (8 slots): HI byte first, then LO, MSB first. ACK_W: released; sample 1 -> NACK<=1, STOP; sample 0 after HI -> WR_BYTE(LO); after LO -> STOP.
- RD_BYTE (8 slots): SDA_OE=0, SDA_OUT=1; shift SDA_IN MSB first into HI then LO shadow register. ACK_R: SDA_OE=1; SDA_OUT=0 after HI (ACK, -> RD_BYTE LO), SDA_OUT=1 after LO (NACK, -> STOP).
- STOP (1 slot): SDA_OE=1; SDA_OUT=0 Q0..Q2, SDA_OUT=1 in Q3; SCL per slot rule (SDA rises while SCL high).
- End of STOP: RD_DATA<=shadow if read with no NACK; DONE=1 one cycle; BUSY<=0; IDLE.
- START_STB while BUSY=1: ignored, no effect on captured values.
- RESET mid-transaction: all outputs to reset values on next edge; no STOP generated; RD_DATA cleared.

## Timing
- Accept: START_STB sampled in IDLE; BUSY=1 and START slot Q0 begin the following cycle.
- Full transaction = 29 slots = 116*QDIV cycles from the first BUSY=1 cycle to the DONE cycle (inclusive of last STOP cycle; DONE on the cycle after).
- NACK at address: 11 slots (START, 8 ADDR, ACK_A, STOP) = 44*QDIV cycles.
- NACK at HI write ack: 20 slots; at LO: 29 slots.
- New START_STB accepted in the DONE cycle (BUSY already 0).
- SDA never changes while SCL=1 except in START (Q1->Q2) and STOP (Q2->Q3).

## Test plan
- Write, QDIV=1, I2C_ADDR=0x2A, WR_DATA=0xBEEF, model ACKs all -> SDA bytes 0x54,0xBE,0xEF MSB first, DONE after 116 cycles, NACK=0.
- Read, ADDR=0x2A, model returns 0x12 then 0x34 -> primary ACKs HI, NACKs LO, RD_DATA=0x1234 on DONE cycle, unchanged before.
- Address mismatch (model never pulls SDA) -> NACK=1, STOP after ACK_A, DONE at 44 cycles, RD_DATA unchanged.
- START_STB pulsed mid-write with different ADDR/data -> ignored; bus traffic matches first request.
- RESET asserted in WR_BYTE -> next cycle SCL=1, SDA_OUT=1, SDA_OE=1, BUSY=0, RD_DATA=0; fresh write completes normally.
- QDIV=3 write -> SCL high/low 6 cycles each, DONE at 348 cycles; SDA edges only when SCL=0 outside START/STOP.
